// File: rtl/uart_pkg.sv
// Shared constants for the UART with FIFOs: register map, STATUS/CTRL bit
// positions, the serial FSM state encoding and the parity helper.
package uart_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DIVL   = 3'd2;
    localparam logic [2:0] ADDR_DIVH   = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    localparam int STAT_RX_EMPTY   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_TX_FULL    = 3;
    localparam int STAT_FRAME_ERR  = 4;
    localparam int STAT_PARITY_ERR = 5;
    localparam int STAT_RX_OVERRUN = 6;

    localparam int CTRL_PEN   = 0;
    localparam int CTRL_PODD  = 1;
    localparam int CTRL_RXIE  = 2;
    localparam int CTRL_TXIE  = 3;
    localparam int CTRL_ERRIE = 4;
    localparam int CTRL_NB    = 5;
    localparam int CTRL_CLR   = 6;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with extra-MSB pointers; a pop and a push in the same cycle on a
// full FIFO are both honoured.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  mem_r [DEPTH];
    logic        do_pop_s;
    logic        do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update.
    always_ff @(posedge CLK) begin
        if (RES) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge CLK) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_io.sv
// UART with TX/RX FIFOs behind a two-phase 8-bit register bus, with
// programmable divisor, optional parity, sticky error flags and a level IRQ.
module uart_fifo_io
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd86
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       IO_REQ,
    input  logic       IO_WRITE,
    input  logic [2:0] IO_ADDR,
    input  logic [7:0] IO_WDATA,
    output logic [7:0] IO_RDATA,
    output logic       IO_RDY,
    output logic       IRQ,
    output logic       UART_TXD,
    input  logic       UART_RXD
);

    logic        pend_r, pend_wr_r;
    logic [2:0]  pend_addr_r;
    logic [7:0]  pend_wdata_r;
    logic [15:0] div_r;
    logic [7:0]  ctrl_r;
    logic [2:0]  err_r;             // {overrun, parity, frame}

    logic        dp_data_s, stall_s, done_s, reg_wr_s, clr_s;
    logic        tx_push_s, rx_pop_s;
    logic [7:0]  status_s, rdata_s;
    logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tx_idle_s;
    logic [7:0]  tx_rd_data_s, rx_rd_data_s;
    logic [2:0]  err_set_s;

    uart_state_e tx_state_r, tx_state_n;
    logic [15:0] tx_baud_r, tx_div_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic        tx_par_r, txd_r, txd_s, tx_load_s, tx_bit_end_s;

    uart_state_e rx_state_r, rx_state_n;
    logic [15:0] rx_baud_r, rx_div_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_par_r, rxd_meta_r, rxd_sync_r, rxd_prev_r;
    logic        rx_bit_end_s, rx_half_s, rx_done_s;

    uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK(CLK), .RES(RES), .push(tx_push_s), .push_data(pend_wdata_r),
        .pop(tx_load_s), .rd_data(tx_rd_data_s), .empty(tx_empty_s), .full(tx_full_s)
    );

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK(CLK), .RES(RES), .push(rx_done_s), .push_data(rx_shift_r),
        .pop(rx_pop_s), .rd_data(rx_rd_data_s), .empty(rx_empty_s), .full(rx_full_s)
    );

    // Data-phase decode: stall conditions and the single-shot push/pop/write strobes.
    always_comb begin
        dp_data_s = pend_r & (pend_addr_r == ADDR_DATA);
        if (dp_data_s && pend_wr_r) begin
            stall_s = tx_full_s;
        end else if (dp_data_s) begin
            stall_s = rx_empty_s & ~ctrl_r[CTRL_NB];
        end else begin
            stall_s = 1'b0;
        end
        done_s    = pend_r & ~stall_s;
        tx_push_s = done_s & dp_data_s & pend_wr_r;
        rx_pop_s  = done_s & dp_data_s & ~pend_wr_r & ~rx_empty_s;
        reg_wr_s  = done_s & pend_wr_r;
        clr_s     = reg_wr_s & (pend_addr_r == ADDR_CTRL) & pend_wdata_r[CTRL_CLR];
    end

    assign tx_idle_s = tx_empty_s & (tx_state_r == UART_IDLE);

    // STATUS byte assembly.
    always_comb begin
        status_s                  = 8'h00;
        status_s[STAT_RX_EMPTY]   = rx_empty_s;
        status_s[STAT_RX_FULL]    = rx_full_s;
        status_s[STAT_TX_EMPTY]   = tx_idle_s;
        status_s[STAT_TX_FULL]    = tx_full_s;
        status_s[STAT_FRAME_ERR]  = err_r[0];
        status_s[STAT_PARITY_ERR] = err_r[1];
        status_s[STAT_RX_OVERRUN] = err_r[2];
    end

    // Read-data mux, driven only during a read data phase.
    always_comb begin
        rdata_s = 8'h00;
        if (pend_r && !pend_wr_r) begin
            case (pend_addr_r)
                ADDR_DATA:   rdata_s = rx_empty_s ? 8'h00 : rx_rd_data_s;
                ADDR_STATUS: rdata_s = status_s;
                ADDR_DIVL:   rdata_s = div_r[7:0];
                ADDR_DIVH:   rdata_s = div_r[15:8];
                ADDR_CTRL:   rdata_s = ctrl_r;
                default:     rdata_s = 8'h00;
            endcase
        end else begin
            rdata_s = 8'h00;
        end
    end

    assign IO_RDATA = rdata_s;
    assign IO_RDY   = ~stall_s;
    assign IRQ      = (ctrl_r[CTRL_RXIE] & ~rx_empty_s) | (ctrl_r[CTRL_TXIE] & tx_idle_s)
                    | (ctrl_r[CTRL_ERRIE] & (|err_r));
    assign UART_TXD = txd_r;

    // Address-phase capture; a stalled data phase holds everything.
    always_ff @(posedge CLK) begin
        if (RES) begin
            pend_r       <= 1'b0;
            pend_wr_r    <= 1'b0;
            pend_addr_r  <= 3'd0;
            pend_wdata_r <= 8'h00;
        end else if (!stall_s) begin
            pend_r <= IO_REQ;
            if (IO_REQ) begin
                pend_wr_r    <= IO_WRITE;
                pend_addr_r  <= IO_ADDR;
                pend_wdata_r <= IO_WDATA;
            end
        end
    end

    assign err_set_s = {rx_done_s & rx_full_s & ~rx_pop_s,
                        rx_done_s & ctrl_r[CTRL_PEN] & (rx_par_r != parity_bit(rx_shift_r, ctrl_r[CTRL_PODD])),
                        rx_done_s & ~rxd_sync_r};

    // Configuration registers and sticky error flags (a new error wins over CLR).
    always_ff @(posedge CLK) begin
        if (RES) begin
            div_r  <= DIV_RESET;
            ctrl_r <= 8'h00;
            err_r  <= 3'b000;
        end else begin
            if (reg_wr_s && pend_addr_r == ADDR_DIVL) begin
                div_r[7:0] <= pend_wdata_r;
            end
            if (reg_wr_s && pend_addr_r == ADDR_DIVH) begin
                div_r[15:8] <= pend_wdata_r;
            end
            if (reg_wr_s && pend_addr_r == ADDR_CTRL) begin
                ctrl_r <= {2'b00, pend_wdata_r[5:0]};
            end
            err_r <= (err_r & ~{3{clr_s}}) | err_set_s;
        end
    end

    assign tx_bit_end_s = (tx_baud_r == tx_div_r);

    // TX state register and shifter datapath.
    always_ff @(posedge CLK) begin
        if (RES) begin
            tx_state_r <= UART_IDLE;
            tx_baud_r  <= 16'd0;
            tx_div_r   <= DIV_RESET;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_par_r   <= 1'b0;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            txd_r      <= txd_s;
            if (tx_load_s) begin
                tx_shift_r <= tx_rd_data_s;
                tx_par_r   <= parity_bit(tx_rd_data_s, ctrl_r[CTRL_PODD]);
                tx_div_r   <= div_r;
                tx_baud_r  <= 16'd0;
                tx_bit_r   <= 3'd0;
            end else if (tx_state_r != UART_IDLE) begin
                if (tx_bit_end_s) begin
                    tx_baud_r <= 16'd0;
                    if (tx_state_r == UART_DATA) begin
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_bit_r   <= tx_bit_r + 3'd1;
                    end
                end else begin
                    tx_baud_r <= tx_baud_r + 16'd1;
                end
            end
        end
    end

    // TX next state; the last stop cycle chains straight into the next START.
    always_comb begin
        tx_state_n = tx_state_r;
        case (tx_state_r)
            UART_IDLE:   if (!tx_empty_s) tx_state_n = UART_START; else tx_state_n = UART_IDLE;
            UART_START:  if (tx_bit_end_s) tx_state_n = UART_DATA; else tx_state_n = UART_START;
            UART_DATA: begin
                if (tx_bit_end_s && tx_bit_r == 3'd7) begin
                    tx_state_n = ctrl_r[CTRL_PEN] ? UART_PARITY : UART_STOP;
                end else begin
                    tx_state_n = UART_DATA;
                end
            end
            UART_PARITY: if (tx_bit_end_s) tx_state_n = UART_STOP; else tx_state_n = UART_PARITY;
            UART_STOP: begin
                if (tx_bit_end_s) begin
                    tx_state_n = tx_empty_s ? UART_IDLE : UART_START;
                end else begin
                    tx_state_n = UART_STOP;
                end
            end
            default:     tx_state_n = UART_IDLE;
        endcase
    end

    // TX line level and FIFO load strobe.
    always_comb begin
        tx_load_s = 1'b0;
        txd_s     = 1'b1;
        case (tx_state_r)
            UART_IDLE:   tx_load_s = ~tx_empty_s;
            UART_START:  txd_s = 1'b0;
            UART_DATA:   txd_s = tx_shift_r[0];
            UART_PARITY: txd_s = tx_par_r;
            UART_STOP:   tx_load_s = tx_bit_end_s & ~tx_empty_s;
            default:     txd_s = 1'b1;
        endcase
    end

    assign rx_bit_end_s = (rx_baud_r == rx_div_r);
    assign rx_half_s    = (rx_baud_r == (rx_div_r >> 1));

    // RX synchroniser, state register and sampling datapath.
    always_ff @(posedge CLK) begin
        if (RES) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
            rx_state_r <= UART_IDLE;
            rx_baud_r  <= 16'd0;
            rx_div_r   <= DIV_RESET;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_par_r   <= 1'b0;
        end else begin
            rxd_meta_r <= UART_RXD;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
            rx_state_r <= rx_state_n;
            if (rx_state_r == UART_IDLE) begin
                rx_baud_r <= 16'd0;
                rx_bit_r  <= 3'd0;
                rx_div_r  <= div_r;
            end else if (rx_state_r == UART_START) begin
                rx_baud_r <= rx_half_s ? 16'd0 : rx_baud_r + 16'd1;
            end else if (rx_bit_end_s) begin
                rx_baud_r <= 16'd0;
                if (rx_state_r == UART_DATA) begin
                    rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                    rx_bit_r   <= rx_bit_r + 3'd1;
                end
                if (rx_state_r == UART_PARITY) begin
                    rx_par_r <= rxd_sync_r;
                end
            end else begin
                rx_baud_r <= rx_baud_r + 16'd1;
            end
        end
    end

    // RX next state; a start bit that is high again at half period is a glitch.
    always_comb begin
        rx_state_n = rx_state_r;
        case (rx_state_r)
            UART_IDLE:  if (rxd_prev_r && !rxd_sync_r) rx_state_n = UART_START; else rx_state_n = UART_IDLE;
            UART_START: begin
                if (rx_half_s) begin
                    rx_state_n = rxd_sync_r ? UART_IDLE : UART_DATA;
                end else begin
                    rx_state_n = UART_START;
                end
            end
            UART_DATA: begin
                if (rx_bit_end_s && rx_bit_r == 3'd7) begin
                    rx_state_n = ctrl_r[CTRL_PEN] ? UART_PARITY : UART_STOP;
                end else begin
                    rx_state_n = UART_DATA;
                end
            end
            UART_PARITY: if (rx_bit_end_s) rx_state_n = UART_STOP; else rx_state_n = UART_PARITY;
            UART_STOP:   if (rx_bit_end_s) rx_state_n = UART_IDLE; else rx_state_n = UART_STOP;
            default:     rx_state_n = UART_IDLE;
        endcase
    end

    // RX frame completion strobe (byte pushed at the stop-bit sample).
    always_comb begin
        if (rx_state_r == UART_STOP) begin
            rx_done_s = rx_bit_end_s;
        end else begin
            rx_done_s = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_io.sv
// Self-checking bench for uart_fifo_io: register vector table, serial TX
// monitor with an expected-byte queue, RX frame injection and corner sequences.
module tb_uart_fifo_io;
    import uart_pkg::*;

    localparam int BIT_CYC = 10;
    localparam int LIMIT   = 3000;

    logic       CLK = 1'b0;
    logic       RES, IO_REQ, IO_WRITE, IRQ, IO_RDY, UART_TXD, UART_RXD;
    logic [2:0] IO_ADDR;
    logic [7:0] IO_WDATA, IO_RDATA;
    logic       loop_en, rxd_drv;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    time        frame_start[$];

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_irq;
    } vec_t;
    vec_t vecs[16];

    always #5 CLK = ~CLK;
    assign UART_RXD = loop_en ? UART_TXD : rxd_drv;

    uart_fifo_io #(.TX_DEPTH(4), .RX_DEPTH(4), .DIV_RESET(16'd20)) dut (
        .CLK(CLK), .RES(RES), .IO_REQ(IO_REQ), .IO_WRITE(IO_WRITE), .IO_ADDR(IO_ADDR),
        .IO_WDATA(IO_WDATA), .IO_RDATA(IO_RDATA), .IO_RDY(IO_RDY), .IRQ(IRQ),
        .UART_TXD(UART_TXD), .UART_RXD(UART_RXD)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output int stall);
        IO_REQ = 1'b1; IO_WRITE = wr; IO_ADDR = a; IO_WDATA = d;
        cycles(1);
        IO_REQ = 1'b0; IO_WRITE = 1'b0; IO_ADDR = 3'd0; IO_WDATA = 8'h00;
        stall = 0;
        while (IO_RDY !== 1'b1 && stall < LIMIT) begin
            cycles(1);
            stall++;
        end
        if (IO_RDY !== 1'b1) begin
            checks++; failures++;
            $display("FAIL bus_timeout: addr %0d got IO_RDY=%b required 1", a, IO_RDY);
        end
        rd = IO_RDATA;
        cycles(1);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int st;
        if (a == ADDR_DATA && mon_en) tx_exp_q.push_back(d);
        bus(1'b1, a, d, rd, st);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp, output int st);
        logic [7:0] rd;
        rd_exp_q.push_back(exp);
        bus(1'b0, a, 8'h00, rd, st);
        check(name, rd, rd_exp_q.pop_front());
    endtask

    task automatic send_frame(input logic [7:0] b, input logic with_par, input logic par, input logic stop);
        rxd_drv = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            cycles(BIT_CYC);
        end
        if (with_par) begin
            rxd_drv = par;
            cycles(BIT_CYC);
        end
        rxd_drv = stop;
        cycles(BIT_CYC);
        rxd_drv = 1'b1;
        cycles(2);
    endtask

    // Serial TX monitor: decodes each frame mid-bit and compares with the queue.
    initial begin : tx_mon
        logic [7:0] b;
        logic [7:0] e;
        logic       st0, sp;
        forever begin
            @(negedge UART_TXD);
            if (mon_en) begin
                frame_start.push_back($time);
                repeat (BIT_CYC / 2) @(posedge CLK);
                #1 st0 = UART_TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(posedge CLK);
                    #1 b[i] = UART_TXD;
                end
                repeat (BIT_CYC) @(posedge CLK);
                #1 sp = UART_TXD;
                e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
                check("tx_frame", {22'd0, st0, b, sp}, {22'd0, 1'b0, e, 1'b1});
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic [9:0] seq;
        int st, n;
        int stv[6];
        time dt;

        RES = 1'b1; IO_REQ = 1'b0; IO_WRITE = 1'b0; IO_ADDR = 3'd0; IO_WDATA = 8'h00;
        loop_en = 1'b0; rxd_drv = 1'b1;
        cycles(4);
        RES = 1'b0;
        cycles(1);
        check("reset_outputs", {IO_RDY, IO_RDATA, IRQ, UART_TXD}, {1'b1, 8'h00, 1'b0, 1'b1});

        // {wr, addr, wdata, expected rdata, expected IRQ}
        vecs[0]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h05, 1'b0};
        vecs[1]  = '{1'b0, ADDR_DIVL,   8'h00, 8'd20, 1'b0};
        vecs[2]  = '{1'b0, ADDR_DIVH,   8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, ADDR_CTRL,   8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 3'd5,        8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 3'd5,        8'hFF, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 3'd7,        8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, ADDR_DIVL,   8'd9,  8'h00, 1'b0};
        vecs[8]  = '{1'b0, ADDR_DIVL,   8'h00, 8'd9,  1'b0};
        vecs[9]  = '{1'b1, ADDR_CTRL,   8'hFF, 8'h00, 1'b1};
        vecs[10] = '{1'b0, ADDR_CTRL,   8'h00, 8'h3F, 1'b1};
        vecs[11] = '{1'b0, ADDR_DATA,   8'h00, 8'h00, 1'b1};
        vecs[12] = '{1'b1, ADDR_CTRL,   8'h04, 8'h00, 1'b0};
        vecs[13] = '{1'b1, ADDR_CTRL,   8'h08, 8'h00, 1'b1};
        vecs[14] = '{1'b1, ADDR_CTRL,   8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b0, ADDR_STATUS, 8'h00, 8'h05, 1'b0};
        for (int i = 0; i < 16; i++) begin
            if (!vecs[i].wr) rd_exp_q.push_back(vecs[i].exp_rdata);
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, rd_exp_q.pop_front());
            check($sformatf("vec%0d_stall_irq", i), {st, IRQ}, {32'd0, vecs[i].exp_irq});
        end

        // 8'hA5 at DIV=9: ten 10-cycle bits, line idles high afterwards.
        mon_en = 1'b1;
        wr(ADDR_DATA, 8'hA5);
        n = 0;
        while (UART_TXD !== 1'b0 && n < 50) begin
            cycles(1);
            n++;
        end
        cycles(BIT_CYC / 2);
        for (int k = 9; k >= 0; k--) begin
            seq[k] = UART_TXD;
            if (k > 0) cycles(BIT_CYC);
        end
        check("a5_waveform", seq, 10'b0101001011);
        cycles(120);
        rd_chk("a5_status_tx_empty", ADDR_STATUS, 8'h05, st);

        // Loopback: back-to-back frames, both bytes received in order.
        loop_en = 1'b1;
        frame_start.delete();
        wr(ADDR_DATA, 8'h3C);
        wr(ADDR_DATA, 8'hC3);
        rd_chk("loop_byte0", ADDR_DATA, 8'h3C, st);
        rd_chk("loop_byte1", ADDR_DATA, 8'hC3, st);
        cycles(30);
        rd_chk("loop_status", ADDR_STATUS, 8'h05, st);
        dt = (frame_start.size() >= 2) ? frame_start[1] - frame_start[0] : 0;
        check("loop_no_gap", 32'(dt), 32'(100 * 10));
        loop_en = 1'b0;

        // TX FIFO of 4: once full, the next DATA write stalls until a frame ends.
        for (int i = 0; i < 6; i++) begin
            tx_exp_q.push_back(8'(8'h11 * (i + 1)));
            bus(1'b1, ADDR_DATA, 8'(8'h11 * (i + 1)), rd, stv[i]);
        end
        check("txfull_first5_no_stall", stv[0] + stv[1] + stv[2] + stv[3] + stv[4], 0);
        check("txfull_6th_stalls_one_frame", (stv[5] >= 50 && stv[5] <= 110), 1);
        cycles(700);
        check("tx_queue_drained", tx_exp_q.size(), 0);
        rd_chk("tx_drain_status", ADDR_STATUS, 8'h05, st);

        // RX FIFO of 4: a fifth frame overruns and is dropped.
        for (int i = 0; i < 5; i++) send_frame(8'(8'hA1 + i), 1'b0, 1'b0, 1'b1);
        rd_chk("overrun_status", ADDR_STATUS, 8'h46, st);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("overrun_byte%0d", i), ADDR_DATA, 8'(8'hA1 + i), st);
        rd_chk("overrun_sticky", ADDR_STATUS, 8'h45, st);
        wr(ADDR_CTRL, 8'h40);
        rd_chk("overrun_cleared", ADDR_STATUS, 8'h05, st);

        // Even parity on 8'h01 needs a 1; sending 0 flags parity_err.
        wr(ADDR_CTRL, 8'h01);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        rd_chk("parity_err_status", ADDR_STATUS, 8'h24, st);
        check("parity_irq_off", IRQ, 1'b0);
        wr(ADDR_CTRL, 8'h11);
        check("parity_irq_errie", IRQ, 1'b1);
        rd_chk("parity_byte", ADDR_DATA, 8'h01, st);
        wr(ADDR_CTRL, 8'h41);
        rd_chk("parity_cleared", ADDR_STATUS, 8'h05, st);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        rd_chk("frame_err_status", ADDR_STATUS, 8'h14, st);
        rd_chk("frame_err_byte", ADDR_DATA, 8'h5A, st);
        wr(ADDR_CTRL, 8'h40);

        // Blocking read on empty RX waits for the frame.
        fork
            begin
                cycles(20);
                send_frame(8'h77, 1'b0, 1'b0, 1'b1);
            end
            rd_chk("blocking_read_byte", ADDR_DATA, 8'h77, st);
        join
        check("blocking_read_stalled", (st > 50), 1);

        // Reset mid-frame aborts TX and restores defaults.
        mon_en = 1'b0;
        wr(ADDR_DATA, 8'h00);
        cycles(35);
        check("midframe_line_low", UART_TXD, 1'b0);
        RES = 1'b1;
        cycles(1);
        RES = 1'b0;
        check("midframe_reset_line", {UART_TXD, IO_RDY, IRQ}, {1'b1, 1'b1, 1'b0});
        rd_chk("midframe_status", ADDR_STATUS, 8'h05, st);
        rd_chk("midframe_divl", ADDR_DIVL, 8'd20, st);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
